// File: rtl/ttw_mem_arb_pkg.sv
// ttw_mem_arb shared types.
// Tag, line-number and per-requester state definitions.
package ttw_mem_arb_pkg;

    localparam int N_REQ  = 4;
    localparam int IDX_W  = $clog2(N_REQ);
    localparam int MCN_W  = 58;
    localparam int LINE_W = 512;

    typedef logic [IDX_W-1:0]  ttw_t;
    typedef logic [MCN_W-1:0]  mcn_t;
    typedef logic [LINE_W-1:0] line_t;

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        WAIT,
        DROP
    } rq_state_e;

endpackage

// File: rtl/ttw_mem_arb_if.sv
// ttw_mem_arb bus bundle.
// master = arbiter side, slave = walkers plus memory side.
interface ttw_mem_arb_if
    import ttw_mem_arb_pkg::*;
#(
    parameter int N = N_REQ
);

    logic [N-1:0]       req_i_valid;
    logic [N-1:0]       req_i_ready;
    logic [N*MCN_W-1:0] req_i_mcn;
    logic [N-1:0]       res_o_valid;
    line_t              res_o_data;
    logic [N-1:0]       kill_i;
    logic               busy_o;

    logic               mem_req_o_valid;
    logic               mem_req_o_ready;
    ttw_t               mem_req_o_bits_idx;
    mcn_t               mem_req_o_bits_mcn;

    logic               mem_res_i_valid;
    logic               mem_res_i_ready;
    ttw_t               mem_res_i_bits_idx;
    line_t              mem_res_i_bits_data;

    modport master (
        input  req_i_valid,
        input  req_i_mcn,
        input  kill_i,
        input  mem_req_o_ready,
        input  mem_res_i_valid,
        input  mem_res_i_bits_idx,
        input  mem_res_i_bits_data,
        output req_i_ready,
        output res_o_valid,
        output res_o_data,
        output busy_o,
        output mem_req_o_valid,
        output mem_req_o_bits_idx,
        output mem_req_o_bits_mcn,
        output mem_res_i_ready
    );

    modport slave (
        output req_i_valid,
        output req_i_mcn,
        output kill_i,
        output mem_req_o_ready,
        output mem_res_i_valid,
        output mem_res_i_bits_idx,
        output mem_res_i_bits_data,
        input  req_i_ready,
        input  res_o_valid,
        input  res_o_data,
        input  busy_o,
        input  mem_req_o_valid,
        input  mem_req_o_bits_idx,
        input  mem_req_o_bits_mcn,
        input  mem_res_i_ready
    );

endinterface

// File: rtl/ttw_mem_arb_rr_pick.sv
// Round-robin pick: first set request at or after ptr.
// Purely combinational; the pointer lives in the parent.
module ttw_mem_arb_rr_pick
    import ttw_mem_arb_pkg::*;
#(
    parameter int N = N_REQ
) (
    input  logic [N-1:0] req,
    input  ttw_t         ptr,
    output logic [N-1:0] gnt,
    output logic         any
);

    ttw_t j;

    // Scan from ptr upward with wrap; the first hit wins
    always_comb begin
        gnt = '0;
        j   = '0;
        for (int k = 0; k < N; k++) begin
            j = IDX_W'((int'(ptr) + k) % N);
            if (req[j] && (gnt == '0)) begin
                gnt[j] = 1'b1;
            end
        end
    end

    assign any = |gnt;

endmodule

// File: rtl/ttw_mem_arb.sv
// Round-robin arbiter for the table-walker memory channel.
// One outstanding line read per requester, responses routed by tag.
module ttw_mem_arb
    import ttw_mem_arb_pkg::*;
#(
    parameter int N = N_REQ
) (
    input  logic          clock,
    input  logic          reset,
    ttw_mem_arb_if.master bus
);

    rq_state_e    state_q [N];
    rq_state_e    state_d [N];
    ttw_t         ptr_q, ptr_d;
    logic         buf_vld_q, buf_vld_d;
    ttw_t         buf_idx_q, buf_idx_d;
    mcn_t         buf_mcn_q, buf_mcn_d;
    logic [N-1:0] res_vld_q, res_vld_d;
    line_t        res_data_q, res_data_d;

    logic         req_fire;
    logic         res_fire;
    logic         buf_free;
    logic         any_gnt;
    logic [N-1:0] elig;
    logic [N-1:0] gnt;
    logic [N-1:0] req_hit;
    logic [N-1:0] res_hit;
    logic [N-1:0] not_idle;
    ttw_t         win;

    assign req_fire = buf_vld_q & bus.mem_req_o_ready;
    assign res_fire = bus.mem_res_i_valid;
    assign buf_free = ~buf_vld_q | req_fire;

    // Per-requester eligibility and event decode; no grant during reset
    always_comb begin
        elig     = '0;
        req_hit  = '0;
        res_hit  = '0;
        not_idle = '0;
        for (int i = 0; i < N; i++) begin
            elig[i]     = bus.req_i_valid[i] & ~bus.kill_i[i]
                        & (state_q[i] == IDLE) & buf_free & reset;
            req_hit[i]  = req_fire & (buf_idx_q == IDX_W'(i));
            res_hit[i]  = res_fire
                        & (bus.mem_res_i_bits_idx == IDX_W'(i));
            not_idle[i] = (state_q[i] != IDLE);
        end
    end

    ttw_mem_arb_rr_pick #(
        .N (N)
    ) u_pick (
        .req (elig),
        .ptr (ptr_q),
        .gnt (gnt),
        .any (any_gnt)
    );

    // One-hot grant to winner index
    always_comb begin
        win = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) begin
                win = IDX_W'(i);
            end
        end
    end

    // Output buffer load/drain and pointer advance
    always_comb begin
        buf_vld_d = buf_vld_q;
        buf_idx_d = buf_idx_q;
        buf_mcn_d = buf_mcn_q;
        ptr_d     = ptr_q;
        if (any_gnt) begin
            buf_vld_d = 1'b1;
            buf_idx_d = win;
            buf_mcn_d = bus.req_i_mcn[int'(win)*MCN_W +: MCN_W];
            ptr_d     = (win == IDX_W'(N - 1)) ? '0 : win + 1'b1;
        end else if (req_fire) begin
            buf_vld_d = 1'b0;
        end
    end

    // Requester state transitions and response routing
    always_comb begin
        state_d    = state_q;
        res_vld_d  = '0;
        res_data_d = res_data_q;
        for (int i = 0; i < N; i++) begin
            unique case (state_q[i])
                IDLE: begin
                    if (gnt[i]) begin
                        state_d[i] = PEND;
                    end
                end
                PEND: begin
                    if (bus.kill_i[i]) begin
                        state_d[i] = DROP;
                    end else if (req_hit[i]) begin
                        state_d[i] = WAIT;
                    end
                end
                WAIT: begin
                    if (res_hit[i]) begin
                        state_d[i] = IDLE;
                        if (!bus.kill_i[i]) begin
                            res_vld_d[i] = 1'b1;
                            res_data_d   = bus.mem_res_i_bits_data;
                        end
                    end else if (bus.kill_i[i]) begin
                        state_d[i] = DROP;
                    end
                end
                DROP: begin
                    if (res_hit[i]) begin
                        state_d[i] = IDLE;
                    end
                end
            endcase
        end
    end

    // State, buffer and response registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                state_q[i] <= IDLE;
            end
            ptr_q      <= '0;
            buf_vld_q  <= 1'b0;
            buf_idx_q  <= '0;
            buf_mcn_q  <= '0;
            res_vld_q  <= '0;
            res_data_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            buf_vld_q  <= buf_vld_d;
            buf_idx_q  <= buf_idx_d;
            buf_mcn_q  <= buf_mcn_d;
            res_vld_q  <= res_vld_d;
            res_data_q <= res_data_d;
        end
    end

    assign bus.req_i_ready        = gnt;
    assign bus.res_o_valid        = res_vld_q;
    assign bus.res_o_data         = res_data_q;
    assign bus.busy_o             = |not_idle;
    assign bus.mem_req_o_valid    = buf_vld_q;
    assign bus.mem_req_o_bits_idx = buf_idx_q;
    assign bus.mem_req_o_bits_mcn = buf_mcn_q;
    assign bus.mem_res_i_ready    = 1'b1;

    // A response may only target a requester with a line in flight
    a_res_tag : assert property (
        @(posedge clock) disable iff (!reset)
        res_fire |-> (state_q[bus.mem_res_i_bits_idx] inside {WAIT, DROP})
    );

endmodule

// File: tb/tb_ttw_mem_arb.sv
// Bench for ttw_mem_arb: directed steps plus random traffic
// compared against a transaction-level reference model.
module tb_ttw_mem_arb;
    import ttw_mem_arb_pkg::*;

    localparam int N = N_REQ;

    logic clock;
    logic reset;

    ttw_mem_arb_if #(.N(N)) bus ();

    ttw_mem_arb #(.N(N)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks;
    int errors;

    // reference model: who holds a line, who was aborted, buffer content
    int           m_ptr;
    bit           m_busy   [N];
    bit           m_killed [N];
    bit           m_full;
    int           m_idx;
    mcn_t         m_mcn;
    logic [N-1:0] m_res;
    line_t        m_data;
    int           memq[$];
    int           gnt_log[$];
    bit           auto_res;
    int           res_pct;
    logic [N-1:0] last_rdy;

    task automatic chk(input string tag, input logic [511:0] obs,
                       input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic line_t rand_line();
        line_t l;
        l = '0;
        for (int w = 0; w < 16; w++) begin
            l[w*32 +: 32] = $urandom;
        end
        return l;
    endfunction

    function automatic mcn_t rand_mcn();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[MCN_W-1:0];
    endfunction

    function automatic bit model_busy();
        bit b;
        b = 1'b0;
        for (int i = 0; i < N; i++) begin
            b = b | m_busy[i];
        end
        return b;
    endfunction

    task automatic model_clear();
        m_ptr  = 0;
        m_full = 1'b0;
        m_idx  = 0;
        m_mcn  = '0;
        m_res  = '0;
        m_data = '0;
        for (int i = 0; i < N; i++) begin
            m_busy[i]   = 1'b0;
            m_killed[i] = 1'b0;
        end
        memq.delete();
    endtask

    task automatic set_mcn(input int i, input mcn_t v);
        bus.req_i_mcn[i*MCN_W +: MCN_W] = v;
    endtask

    // Present a response for a tag the memory currently holds
    task automatic respond(input int tag, input line_t data);
        bit found;
        found = 1'b0;
        for (int p = 0; p < memq.size(); p++) begin
            if (!found && memq[p] == tag) begin
                memq.delete(p);
                found = 1'b1;
            end
        end
        chk("resp_tag_held", found, 1'b1);
        bus.mem_res_i_valid     = 1'b1;
        bus.mem_res_i_bits_idx  = ttw_t'(tag);
        bus.mem_res_i_bits_data = data;
    endtask

    // One clock: inputs already driven at negedge
    task automatic cycle();
        int           w;
        bit           fire;
        bit           free;
        int           t;
        logic [N-1:0] rdy_exp;
        if (auto_res && memq.size() > 0
            && ($urandom_range(99) < res_pct)) begin
            int p;
            p = $urandom_range(memq.size() - 1);
            bus.mem_res_i_valid     = 1'b1;
            bus.mem_res_i_bits_idx  = ttw_t'(memq[p]);
            bus.mem_res_i_bits_data = rand_line();
            memq.delete(p);
        end
        #1;
        fire = m_full && bus.mem_req_o_ready;
        free = !m_full || fire;
        w = -1;
        if (free) begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (w < 0 && bus.req_i_valid[j] && !bus.kill_i[j]
                    && !m_busy[j]) begin
                    w = j;
                end
            end
        end
        rdy_exp = '0;
        if (w >= 0) rdy_exp[w] = 1'b1;
        last_rdy = bus.req_i_ready;
        chk("req_ready", last_rdy, rdy_exp);
        for (int i = 0; i < N; i++) begin
            if (last_rdy[i]) gnt_log.push_back(i);
        end
        if (fire) memq.push_back(m_idx);
        for (int i = 0; i < N; i++) begin
            if (bus.kill_i[i] && m_busy[i]) m_killed[i] = 1'b1;
        end
        m_res = '0;
        if (bus.mem_res_i_valid) begin
            t = int'(bus.mem_res_i_bits_idx);
            if (m_busy[t] && !m_killed[t]) begin
                m_res[t] = 1'b1;
                m_data   = bus.mem_res_i_bits_data;
            end
            m_busy[t]   = 1'b0;
            m_killed[t] = 1'b0;
        end
        if (w >= 0) begin
            m_busy[w]   = 1'b1;
            m_killed[w] = 1'b0;
            m_full      = 1'b1;
            m_idx       = w;
            m_mcn       = bus.req_i_mcn[w*MCN_W +: MCN_W];
            m_ptr       = (w + 1) % N;
        end else if (fire) begin
            m_full = 1'b0;
        end
        @(posedge clock);
        @(negedge clock);
        chk("mem_valid", bus.mem_req_o_valid, m_full);
        if (m_full) begin
            chk("mem_idx", bus.mem_req_o_bits_idx, m_idx);
            chk("mem_mcn", bus.mem_req_o_bits_mcn, m_mcn);
        end
        chk("res_valid", bus.res_o_valid, m_res);
        if (m_res != '0) chk("res_data", bus.res_o_data, m_data);
        chk("busy", bus.busy_o, model_busy());
        chk("res_ready", bus.mem_res_i_ready, 1'b1);
        bus.mem_res_i_valid = 1'b0;
        bus.kill_i          = '0;
    endtask

    // Assert reset, check every output asynchronously, then release
    task automatic do_reset();
        reset = 1'b0;
        #1;
        chk("rst_req_ready", bus.req_i_ready, '0);
        chk("rst_res_valid", bus.res_o_valid, '0);
        chk("rst_res_data", bus.res_o_data, '0);
        chk("rst_mem_valid", bus.mem_req_o_valid, 1'b0);
        chk("rst_mem_idx", bus.mem_req_o_bits_idx, '0);
        chk("rst_mem_mcn", bus.mem_req_o_bits_mcn, '0);
        chk("rst_res_ready", bus.mem_res_i_ready, 1'b1);
        chk("rst_busy", bus.busy_o, 1'b0);
        bus.req_i_valid     = '0;
        bus.kill_i          = '0;
        bus.mem_res_i_valid = 1'b0;
        bus.mem_req_o_ready = 1'b1;
        auto_res            = 1'b0;
        model_clear();
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        checks                  = 0;
        errors                  = 0;
        reset                   = 1'b0;
        res_pct                 = 0;
        bus.req_i_valid         = '0;
        bus.req_i_mcn           = '0;
        bus.kill_i              = '0;
        bus.mem_req_o_ready     = 1'b1;
        bus.mem_res_i_valid     = 1'b0;
        bus.mem_res_i_bits_idx  = '0;
        bus.mem_res_i_bits_data = '0;
        @(negedge clock);
        do_reset();

        // two requesters at once: 0 then 2, pointer lands on 3
        bus.req_i_valid = 4'b0101;
        set_mcn(0, 58'h0AA_0000_1234);
        set_mcn(2, 58'h155_BEEF_0002);
        cycle();
        chk("t1_gnt0", last_rdy, 4'b0001);
        chk("t1_idx0", bus.mem_req_o_bits_idx, 0);
        chk("t1_mcn0", bus.mem_req_o_bits_mcn, 58'h0AA_0000_1234);
        bus.req_i_valid = 4'b0100;
        cycle();
        chk("t1_gnt2", last_rdy, 4'b0100);
        chk("t1_idx2", bus.mem_req_o_bits_idx, 2);
        chk("t1_mcn2", bus.mem_req_o_bits_mcn, 58'h155_BEEF_0002);
        bus.req_i_valid = '0;
        cycle();
        respond(0, {16{32'h0BAD_F00D}});
        cycle();
        chk("t1_res0", bus.res_o_valid, 4'b0001);
        respond(2, {16{32'h1234_5678}});
        cycle();
        chk("t1_res2", bus.res_o_valid, 4'b0100);
        chk("t1_dat2", bus.res_o_data, {16{32'h1234_5678}});
        bus.req_i_valid = 4'b1011;
        cycle();
        chk("t1_ptr3", last_rdy, 4'b1000);
        do_reset();

        // everyone requesting, memory answering at once
        bus.req_i_valid = '1;
        auto_res        = 1'b1;
        res_pct         = 100;
        gnt_log.delete();
        repeat (13) cycle();
        chk("t2_ngnt", gnt_log.size() >= 12, 1'b1);
        for (int k = 0; k < 12 && k < gnt_log.size(); k++) begin
            chk("t2_order", gnt_log[k], k % N);
        end
        do_reset();

        // stalled downstream: buffer holds steady, no new grant
        bus.mem_req_o_ready = 1'b0;
        bus.req_i_valid     = 4'b0010;
        set_mcn(1, 58'h2C0_FFEE_0101);
        cycle();
        chk("t3_gnt1", last_rdy, 4'b0010);
        bus.req_i_valid = 4'b0101;
        repeat (5) begin
            cycle();
            chk("t3_nogn", last_rdy, 4'b0000);
            chk("t3_vld", bus.mem_req_o_valid, 1'b1);
            chk("t3_idx", bus.mem_req_o_bits_idx, 1);
            chk("t3_mcn", bus.mem_req_o_bits_mcn, 58'h2C0_FFEE_0101);
        end
        bus.mem_req_o_ready = 1'b1;
        cycle();
        chk("t3_gnt2", last_rdy, 4'b0100);
        do_reset();

        // kill while waiting: response swallowed, requester freed
        bus.req_i_valid = 4'b0010;
        cycle();
        bus.req_i_valid = '0;
        cycle();
        bus.kill_i = 4'b0010;
        cycle();
        chk("t4_busy", bus.busy_o, 1'b1);
        respond(1, {64{8'hA5}});
        cycle();
        chk("t4_nores", bus.res_o_valid, 4'b0000);
        chk("t4_idle", bus.busy_o, 1'b0);
        bus.req_i_valid = 4'b0010;
        cycle();
        chk("t4_regnt", last_rdy, 4'b0010);
        do_reset();

        // kill colliding with response, and with request
        bus.req_i_valid = 4'b1000;
        cycle();
        bus.req_i_valid = '0;
        cycle();
        bus.kill_i = 4'b1000;
        respond(3, {16{32'hCAFE_0003}});
        cycle();
        chk("t5_nores", bus.res_o_valid, 4'b0000);
        chk("t5_idle", bus.busy_o, 1'b0);
        bus.req_i_valid = 4'b0100;
        bus.kill_i      = 4'b0100;
        cycle();
        chk("t5_kreq", last_rdy[2], 1'b0);
        cycle();
        chk("t5_gnt2", last_rdy, 4'b0100);
        do_reset();

        // reset with lines in PEND and WAIT
        bus.req_i_valid = 4'b0011;
        cycle();
        cycle();
        bus.mem_req_o_ready = 1'b0;
        bus.req_i_valid     = 4'b0110;
        cycle();
        chk("t6_busy", bus.busy_o, 1'b1);
        #2;
        do_reset();
        bus.req_i_valid = 4'b1001;
        cycle();
        chk("t6_ptr0", last_rdy, 4'b0001);
        do_reset();

        // random traffic against the model
        auto_res = 1'b1;
        res_pct  = 40;
        repeat (3000) begin
            bus.req_i_valid = N'($urandom);
            for (int i = 0; i < N; i++) begin
                bus.kill_i[i] = ($urandom_range(15) == 0);
                set_mcn(i, rand_mcn());
            end
            bus.mem_req_o_ready = ($urandom_range(3) != 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
